ufm_read_arbiter: RTL
=====================

// Module: ufm_read_arbiter
// PURPOSE
//  Shares the single UFM Avalon-MM read port between NUM_REQ requesters, e.g. the boot shadow copier and a runtime CPU bridge.
//  Round-robin grant per transaction; a grant is held from command issue until the last read-data beat of the burst returns.
//  Sits between the requesters and the UFM IP; forwards waitrequest, readdatavalid and read data to the granted requester only.
// PARAMETERS
//  NUM_REQ      2     number of requesters (2..4)
//  ADDR_W       9     UFM word-address width
//  TIMEOUT_CYC  1024  cycles DATA may wait for a beat before abort (UFM_ARB_TIMEOUT_EN only)
// PORTS
//  clk             in   1              system clock
//  reset_n         in   1              async active-low reset
//  req_read_i      in   NUM_REQ        per-requester read request, held until its wait drops
//  req_addr_i      in   NUM_REQ*ADDR_W packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_burst_i     in   NUM_REQ*2      packed burst counts, requester i at [i*2 +: 2]
//  req_wait_o      out  NUM_REQ        per-requester waitrequest
//  req_valid_o     out  NUM_REQ        per-requester readdatavalid
//  req_data_o      out  32             shared read data, qualified by req_valid_o
//  ufm_read_o      out  1              UFM read command
//  ufm_addr_o      out  ADDR_W         UFM address
//  ufm_burst_o     out  2              UFM burst count
//  ufm_wait_req_i  in   1              UFM waitrequest
//  ufm_valid_i     in   1              UFM readdatavalid
//  ufm_data_i      in   32             UFM read data
//  grant_o         out  NUM_REQ        one-hot current owner, 0 when idle
//  busy_o          out  1              high in ISSUE or DATA
//  timeout_o       out  1              sticky abort flag (tied 0 without macro)
// BEHAVIOUR
//  Reset: state IDLE, grant_o=0, ufm_read_o=0, ufm_addr_o=0, ufm_burst_o=0, req_wait_o=all 1s, req_valid_o=0, busy_o=0, timeout_o=0.
//  Reset: last-granted pointer = NUM_REQ-1, so requester 0 wins first.
//  Asserting reset_n low mid-transaction returns to reset state immediately; in-flight beats after release are dropped.
//  IDLE:
//    - Scan req_read_i round-robin starting after the last-granted index.
//    - Winner w: register grant_o, address and burst; drop to ISSUE next cycle (1-cycle arbitration latency).
//    - Burst count 0 is treated as 1.
//  ISSUE:
//    - ufm_read_o=1; addr and burst held stable.
//    - req_wait_o[w] mirrors ufm_wait_req_i.
//    - On a cycle with ufm_read_o=1 and ufm_wait_req_i=0: command accepted, ufm_read_o->0 next cycle.
//    - Load beat counter with burst, go to DATA.
//  DATA:
//    - req_valid_o[w]=ufm_valid_i and req_data_o=ufm_data_i, combinational pass-through (0 latency).
//    - Counter decrements on each valid; last beat -> IDLE and update pointer to w.
//  req_wait_o[i] is 1 for every i not in the ISSUE state as owner; non-owners never see valid.
//  ufm_valid_i seen in IDLE or ISSUE is ignored (spurious) and never forwarded.
//  A requester dropping req_read_i after grant does not cancel; the burst still completes.
//  Simultaneous requests: strict rotation, so no requester waits more than NUM_REQ-1 transactions.
//  Back-to-back: the IDLE cycle between transactions is mandatory (one bubble); one transaction outstanding max.
// CONFIGURATION
//  UFM_ARB_TIMEOUT_EN defined:
//    - Counter runs in ISSUE and DATA, cleared on each accept or valid beat.
//    - Reaching TIMEOUT_CYC forces IDLE, deasserts ufm_read_o, sets sticky timeout_o (cleared only by reset) and advances the pointer.
//  UFM_ARB_TIMEOUT_EN undefined:
//    - No counter; timeout_o tied 0; a hung UFM stalls the arbiter indefinitely.
// TESTING
//  1. Reset, req_read_i=01, addr0=0x010, burst=1, wait high 3 cycles:
//     -> ufm_read_o held 4 cycles, addr 0x010, one valid to req 0 only, then IDLE.
//  2. req_read_i=11 held continuously, burst=1 each:
//     -> grants alternate 01,10,01,10; req_valid_o never asserted for the non-owner.
//  3. Burst=2 with valids spaced 1 then 5 cycles:
//     -> grant held until 2nd valid; ufm_read_o low after accept; data 0xDEADBEEF,0x12345678 passed through.
//  4. ufm_valid_i pulse while IDLE -> req_valid_o stays 0, state unchanged.
//  5. reset_n pulled low in DATA after 1 of 2 beats -> all outputs at reset values, next grant goes to requester 0.
//  6. UFM_ARB_TIMEOUT_EN with TIMEOUT_CYC=16, no valid after accept:
//     -> IDLE after 16 cycles, timeout_o=1 sticky, other requester served next.

Source files
------------

// File: rtl/ufm_read_arbiter.sv
// Round-robin arbiter sharing the single UFM Avalon-MM read port between NUM_REQ requesters.
// Optional watchdog abort enabled by defining UFM_ARB_TIMEOUT_EN.
module ufm_read_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_read_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*2-1:0]      req_burst_i,
  output logic [NUM_REQ-1:0]        req_wait_o,
  output logic [NUM_REQ-1:0]        req_valid_o,
  output logic [31:0]               req_data_o,
  output logic                      ufm_read_o,
  output logic [ADDR_W-1:0]         ufm_addr_o,
  output logic [1:0]                ufm_burst_o,
  input  logic                      ufm_wait_req_i,
  input  logic                      ufm_valid_i,
  input  logic [31:0]               ufm_data_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("ufm_read_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYC >= 1");
  end

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [1:0]         burst_q, burst_d;
  logic [1:0]         beats_q, beats_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [ADDR_W-1:0]  win_addr;
  logic [1:0]         win_burst;
  logic               accept;
  logic               beat;
  logic               tmo_hit;

  assign accept = (state_q == ST_ISSUE) && !ufm_wait_req_i;
  assign beat   = (state_q == ST_DATA) && ufm_valid_i;

  // Rotating priority: the first requester after the last owner wins.
  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!win_found && req_read_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_addr  = '0;
    win_burst = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        win_burst = req_burst_i[k*2 +: 2];
      end
    end
  end

`ifdef UFM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;

  // Counts cycles without progress; any accept or beat restarts the window.
  always_comb begin
    tmo_hit   = (state_q != ST_IDLE) && !accept && !beat &&
                (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    if (state_q == ST_IDLE || accept || beat || tmo_hit) begin
      tmo_cnt_d = '0;
    end
    timeout_d = timeout_q | tmo_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    beats_d = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          addr_d  = win_addr;
          burst_d = (win_burst == 2'd0) ? 2'd1 : win_burst;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          beats_d = burst_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          if (beats_q == 2'd1) begin
            state_d = ST_IDLE;
            grant_d = '0;
            last_d  = owner_q;
          end else begin
            beats_d = beats_q - 2'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    // An abort releases the port and still rotates priority past the stuck owner.
    if (tmo_hit) begin
      state_d = ST_IDLE;
      grant_d = '0;
      last_d  = owner_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      addr_q  <= '0;
      burst_q <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      beats_q <= beats_d;
    end
  end

  // Only the owner sees the UFM handshake; everyone else is held off.
  assign req_wait_o  = ~(grant_q & {NUM_REQ{(state_q == ST_ISSUE) && !ufm_wait_req_i}});
  assign req_valid_o = grant_q & {NUM_REQ{beat}};
  assign req_data_o  = ufm_data_i;

  assign ufm_read_o  = (state_q == ST_ISSUE);
  assign ufm_addr_o  = addr_q;
  assign ufm_burst_o = burst_q;
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
